// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Definitions shared by the reorder buffer, Dispatcher, LSB and register file:
// buffer depth, rename-tag width, the "no tag" encoding, the entry type
// encodings and small tag/index conversion helpers.
// Tags are index+1, so tag 0 never names an entry.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 5;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;
    localparam int IDX_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = IDX_W + 1;

    localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b0}};

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2,
        ROB_OTHER  = 2'd3
    } rob_type_e;

    // A tag names a real entry only when it lies in 1..ROB_DEPTH.
    function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
        return (tag != NO_TAG) && (tag <= TAG_W'(ROB_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1'b1));
    endfunction

    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(idx) + TAG_W'(1'b1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every reorder-buffer signal except clock and reset.
//   Allocation : alloc_valid/type/rd/pred_taken/pc_alt in, alloc_tag/full out
//   Query      : query_tag1/2 in, query_ready1/2 + query_value1/2 out
//   CDBs       : alu_* and lsb_* broadcasts in
//   Commit     : flag_commit, rd/Q/V_to_RegFile, store_commit/store_tag,
//                flag_rollback/rollback_pc out
//   rdy        : global ready (stall when low)
// modport master = environment side, modport slave = the reorder buffer.
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic               rdy;
    logic               alloc_valid;
    rob_type_e          alloc_type;
    logic [REG_W-1:0]   alloc_rd;
    logic               alloc_pred_taken;
    logic [XLEN-1:0]    alloc_pc_alt;
    logic [TAG_W-1:0]   alloc_tag;
    logic               full;

    logic [TAG_W-1:0]   query_tag1;
    logic [TAG_W-1:0]   query_tag2;
    logic               query_ready1;
    logic               query_ready2;
    logic [XLEN-1:0]    query_value1;
    logic [XLEN-1:0]    query_value2;

    logic               alu_valid;
    logic [TAG_W-1:0]   alu_tag;
    logic [XLEN-1:0]    alu_value;
    logic               alu_taken;
    logic               lsb_valid;
    logic [TAG_W-1:0]   lsb_tag;
    logic [XLEN-1:0]    lsb_value;

    logic               flag_commit;
    logic [REG_W-1:0]   rd_to_RegFile;
    logic [TAG_W-1:0]   Q_to_RegFile;
    logic [XLEN-1:0]    V_to_RegFile;
    logic               flag_rollback;
    logic [XLEN-1:0]    rollback_pc;
    logic               store_commit;
    logic [TAG_W-1:0]   store_tag;

    modport master (
        output rdy, alloc_valid, alloc_type, alloc_rd, alloc_pred_taken, alloc_pc_alt,
        output query_tag1, query_tag2,
        output alu_valid, alu_tag, alu_value, alu_taken, lsb_valid, lsb_tag, lsb_value,
        input  alloc_tag, full, query_ready1, query_ready2, query_value1, query_value2,
        input  flag_commit, rd_to_RegFile, Q_to_RegFile, V_to_RegFile,
        input  flag_rollback, rollback_pc, store_commit, store_tag
    );

    modport slave (
        input  rdy, alloc_valid, alloc_type, alloc_rd, alloc_pred_taken, alloc_pc_alt,
        input  query_tag1, query_tag2,
        input  alu_valid, alu_tag, alu_value, alu_taken, lsb_valid, lsb_tag, lsb_value,
        output alloc_tag, full, query_ready1, query_ready2, query_value1, query_value2,
        output flag_commit, rd_to_RegFile, Q_to_RegFile, V_to_RegFile,
        output flag_rollback, rollback_pc, store_commit, store_tag
    );

endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order commit stage. One tagged entry is allocated per dispatched
// instruction, results are captured from the ALU and LSB CDBs, and the head
// entry retires into the register file (or releases a store to the LSB).
// A mispredicted branch at commit flushes the whole buffer and redirects.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : reorder_buffer_if.slave (allocation, query, CDB and commit signals)
// alloc_tag, full and the query outputs are combinational; all commit
// outputs are registered and the pulse outputs last one cycle.
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave bus
);

    // Entry storage
    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_ready;
    logic [ROB_DEPTH-1:0] r_pred;
    logic [ROB_DEPTH-1:0] r_actual;
    rob_type_e            r_type   [ROB_DEPTH];
    logic [REG_W-1:0]     r_rd     [ROB_DEPTH];
    logic [XLEN-1:0]      r_value  [ROB_DEPTH];
    logic [XLEN-1:0]      r_pc_alt [ROB_DEPTH];

    logic [IDX_W-1:0]     r_head;
    logic [IDX_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    // Registered commit outputs
    logic                 r_flag_commit;
    logic [REG_W-1:0]     r_rd_out;
    logic [TAG_W-1:0]     r_q_out;
    logic [XLEN-1:0]      r_v_out;
    logic                 r_flag_rollback;
    logic [XLEN-1:0]      r_rollback_pc;
    logic                 r_store_commit;
    logic [TAG_W-1:0]     r_store_tag;

    logic                 w_full;
    logic                 w_alloc_en;
    logic                 w_commit_en;
    logic                 w_rf_write;
    logic                 w_store_rel;
    logic                 w_mispredict;
    logic [IDX_W-1:0]     w_alu_idx;
    logic [IDX_W-1:0]     w_lsb_idx;
    logic                 w_alu_hit;
    logic                 w_lsb_hit;
    logic [IDX_W-1:0]     w_q1_idx;
    logic [IDX_W-1:0]     w_q2_idx;
    logic                 w_q1_hit;
    logic                 w_q2_hit;

    // Full is judged from the current count, so an allocation coinciding
    // with a commit is still refused while the buffer is full.
    assign w_full      = (r_count == CNT_W'(ROB_DEPTH));
    assign w_alloc_en  = bus.rdy && bus.alloc_valid && !w_full;
    assign w_commit_en = bus.rdy && r_busy[r_head] && r_ready[r_head];

    // Branches write a link register only when rd is non-zero; rd=0 never writes.
    assign w_rf_write   = ((r_type[r_head] == ROB_REG) || (r_type[r_head] == ROB_BRANCH))
                          && (r_rd[r_head] != 5'd0);
    assign w_store_rel  = (r_type[r_head] == ROB_STORE);
    assign w_mispredict = w_commit_en && (r_type[r_head] == ROB_BRANCH)
                          && (r_actual[r_head] != r_pred[r_head]);

    // Writebacks only land on live entries; stale or tag-0 broadcasts drop out.
    assign w_alu_idx = tag_to_idx(bus.alu_tag);
    assign w_lsb_idx = tag_to_idx(bus.lsb_tag);
    assign w_alu_hit = bus.alu_valid && tag_valid(bus.alu_tag) && r_busy[w_alu_idx];
    assign w_lsb_hit = bus.lsb_valid && tag_valid(bus.lsb_tag) && r_busy[w_lsb_idx];

    // Operand queries see a result only while its entry is still live.
    assign w_q1_idx = tag_to_idx(bus.query_tag1);
    assign w_q2_idx = tag_to_idx(bus.query_tag2);
    assign w_q1_hit = tag_valid(bus.query_tag1) && r_busy[w_q1_idx] && r_ready[w_q1_idx];
    assign w_q2_hit = tag_valid(bus.query_tag2) && r_busy[w_q2_idx] && r_ready[w_q2_idx];

    assign bus.query_ready1  = w_q1_hit;
    assign bus.query_ready2  = w_q2_hit;
    assign bus.query_value1  = w_q1_hit ? r_value[w_q1_idx] : 32'd0;
    assign bus.query_value2  = w_q2_hit ? r_value[w_q2_idx] : 32'd0;

    assign bus.alloc_tag     = idx_to_tag(r_tail);
    assign bus.full          = w_full;
    assign bus.flag_commit   = r_flag_commit;
    assign bus.rd_to_RegFile = r_rd_out;
    assign bus.Q_to_RegFile  = r_q_out;
    assign bus.V_to_RegFile  = r_v_out;
    assign bus.flag_rollback = r_flag_rollback;
    assign bus.rollback_pc   = r_rollback_pc;
    assign bus.store_commit  = r_store_commit;
    assign bus.store_tag     = r_store_tag;

    // Buffer state, writeback capture, commit outputs and rollback flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy          <= {ROB_DEPTH{1'b0}};
            r_ready         <= {ROB_DEPTH{1'b0}};
            r_pred          <= {ROB_DEPTH{1'b0}};
            r_actual        <= {ROB_DEPTH{1'b0}};
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_type[i]   <= ROB_REG;
                r_rd[i]     <= 5'd0;
                r_value[i]  <= 32'd0;
                r_pc_alt[i] <= 32'd0;
            end
            r_head          <= {IDX_W{1'b0}};
            r_tail          <= {IDX_W{1'b0}};
            r_count         <= {CNT_W{1'b0}};
            r_flag_commit   <= 1'b0;
            r_rd_out        <= 5'd0;
            r_q_out         <= 5'd0;
            r_v_out         <= 32'd0;
            r_flag_rollback <= 1'b0;
            r_rollback_pc   <= 32'd0;
            r_store_commit  <= 1'b0;
            r_store_tag     <= 5'd0;
        end else if (bus.rdy) begin
            r_flag_commit   <= 1'b0;
            r_flag_rollback <= 1'b0;
            r_store_commit  <= 1'b0;

            if (w_commit_en) begin
                if (w_rf_write) begin
                    r_flag_commit <= 1'b1;
                    r_rd_out      <= r_rd[r_head];
                    r_q_out       <= idx_to_tag(r_head);
                    r_v_out       <= r_value[r_head];
                end
                if (w_store_rel) begin
                    r_store_commit <= 1'b1;
                    r_store_tag    <= idx_to_tag(r_head);
                end
                if (w_mispredict) begin
                    r_flag_rollback <= 1'b1;
                    r_rollback_pc   <= r_pc_alt[r_head];
                end
            end

            if (w_mispredict) begin
                // Flush: everything younger than the branch is discarded,
                // including any allocation or writeback arriving this edge.
                r_busy  <= {ROB_DEPTH{1'b0}};
                r_ready <= {ROB_DEPTH{1'b0}};
                r_head  <= {IDX_W{1'b0}};
                r_tail  <= {IDX_W{1'b0}};
                r_count <= {CNT_W{1'b0}};
            end else begin
                if (w_commit_en) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + IDX_W'(1'b1);
                end
                if (w_alloc_en) begin
                    r_busy[r_tail]   <= 1'b1;
                    // Stores and OTHER carry no CDB result, so they are born ready.
                    r_ready[r_tail]  <= (bus.alloc_type == ROB_STORE) || (bus.alloc_type == ROB_OTHER);
                    r_type[r_tail]   <= bus.alloc_type;
                    r_rd[r_tail]     <= bus.alloc_rd;
                    r_pred[r_tail]   <= bus.alloc_pred_taken;
                    r_actual[r_tail] <= 1'b0;
                    r_value[r_tail]  <= 32'd0;
                    r_pc_alt[r_tail] <= bus.alloc_pc_alt;
                    r_tail           <= r_tail + IDX_W'(1'b1);
                end
                if (w_alu_hit) begin
                    r_ready[w_alu_idx] <= 1'b1;
                    r_value[w_alu_idx] <= bus.alu_value;
                    if (r_type[w_alu_idx] == ROB_BRANCH) begin
                        r_actual[w_alu_idx] <= bus.alu_taken;
                    end
                end
                if (w_lsb_hit) begin
                    r_ready[w_lsb_idx] <= 1'b1;
                    r_value[w_lsb_idx] <= bus.lsb_value;
                end
                r_count <= r_count + {{IDX_W{1'b0}}, w_alloc_en} - {{IDX_W{1'b0}}, w_commit_en};
            end
        end else begin
            // Stalled: state holds, pulses drop.
            r_flag_commit   <= 1'b0;
            r_flag_rollback <= 1'b0;
            r_store_commit  <= 1'b0;
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order commit stage of the Tomasulo core. Allocates one tagged entry per dispatched instruction and captures results broadcast by the ALU and LSB CDBs. Retires the head entry into the register file (flag_commit/rd/Q/V) and releases committed stores to the LSB. Detects branch mispredictions at commit and issues the global rollback and redirect PC.

Parameters:
DEPTH, 16, number of entries (power of two); tag = index+1, so tags are 1..16 and 0 means "no tag".
TAG_W, 5, width of rename tags (Q), matching the register-file Q width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when low, all state holds and pulse outputs are 0
alloc_valid  in  1  Dispatcher allocates one entry this cycle
alloc_type  in  2  0=REG, 1=BRANCH, 2=STORE, 3=OTHER (no rd write)
alloc_rd  in  5  destination register (ignored for STORE)
alloc_pred_taken  in  1  predictor decision (BRANCH only)
alloc_pc_alt  in  32  PC to redirect to if the prediction was wrong
alloc_tag  out  5  tag the next allocation receives (head-independent, combinational from tail)
full  out  1  count==DEPTH; Dispatcher must not allocate
query_tag1, query_tag2  in  5 each  operand tags from the register file
query_ready1, query_ready2  out  1 each  entry holds its result (combinational; 0 for tag 0)
query_value1, query_value2  out  32 each  that result
alu_valid, lsb_valid  in  1 each  CDB broadcasts
alu_tag, lsb_tag  in  5 each  producing tag
alu_value, lsb_value  in  32 each  result value
alu_taken  in  1  actual branch outcome (BRANCH entries)
flag_commit  out  1  pulse: register-file write of rd/Q/V
rd_to_RegFile  out  5  committed rd
Q_to_RegFile  out  5  committed tag
V_to_RegFile  out  32  committed value
flag_rollback  out  1  pulse: flush the whole pipeline
rollback_pc  out  32  redirect PC, valid with flag_rollback
store_commit  out  1  pulse: LSB may perform the store
store_tag  out  5  tag of the released store

Behaviour:
- State: circular array of busy/ready/type/rd/value/pred/actual/pc_alt; head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH); count (0..DEPTH).
- Reset (rst=0, async): head=tail=count=0, all busy=0; every output register is 0. alloc_tag=1 and full=0 as a consequence.
- Allocate: when alloc_valid&&!full&&rdy, write the entry at tail (busy=1, ready=0; STORE and OTHER become ready=1 immediately) and advance tail. Allocation while full is ignored.
- Writeback: each valid CDB whose tag matches a busy entry sets ready=1 and value; a BRANCH entry also latches actual=alu_taken. ALU and LSB may hit different entries in the same cycle. Non-busy or tag-0 writebacks are ignored.
- Commit: at most one per cycle, when head is busy&&ready. Outputs are registered, so they appear the cycle after the edge that observes a ready head; a writeback to the head at edge N gives commit outputs after edge N+1. Pulses last exactly one cycle.
  - REG, and BRANCH with rd!=0: flag_commit=1 with rd/Q=head tag/V.
  - STORE: store_commit=1, store_tag=head tag.
  - BRANCH with actual!=pred: flag_rollback=1, rollback_pc=pc_alt. Any link write is committed in the same cycle.
- Rollback: in the same edge that commits the mispredicted branch, clear all busy bits and set head=tail=count=0. Allocations and writebacks in that edge are dropped.
- Simultaneous allocate and commit: count is unchanged. When full, the allocation is still refused, because full is evaluated from the current count.
- Commits of rd=0 never assert flag_commit.
- rdy=0: no state change; pulse outputs drop to 0.

Decomposition:
- Shared defines: ROB_DEPTH, TAG_W, NO_TAG=0, and the type encodings ROB_REG/ROB_BRANCH/ROB_STORE/ROB_OTHER. Dispatcher, LSB and register file use the same definitions.
- Single module; no sub-module is warranted.

Test Plan:
- Reset mid-run with 5 entries live -> next cycle full=0, alloc_tag=1, every pulse output 0.
- Allocate REG rd=5 (tag 1); ALU writeback tag1=0x1234 -> one cycle later flag_commit=1, rd=5, Q=1, V=0x1234; then query_tag1=1 returns ready only before commit.
- Allocate 16 entries -> full=1 and a 17th alloc is ignored. Complete tag 1 -> after commit full=0, and tail wraps so alloc_tag=1 again.
- Out-of-order completion: tags 1,2,3 with writebacks 3,2,1 (ALU+LSB together on 3 and 2) -> commits in order 1,2,3 on three consecutive cycles.
- Store at tag 2 behind REG tag 1 -> store_commit=1, store_tag=2 only after tag 1 commits.
- BRANCH tag 1 with pred=1, actual=0, pc_alt=0x1004, followed by tags 2-4 -> flag_rollback=1, rollback_pc=0x1004; next cycle count=0, alloc_tag=1, and tags 2-4 never commit.
